// File: rtl/biu_constants_pkg.sv
// -----------------------------------------------------------------------------
// biu_constants_pkg
//  Shared constants of the data bus interface unit. Only the access-size
//  encoding is needed by the dmem arbiter.
// -----------------------------------------------------------------------------
package biu_constants_pkg;

   typedef enum logic [1:0] {
      BIU_SIZE_BYTE = 2'd0,
      BIU_SIZE_HALF = 2'd1,
      BIU_SIZE_WORD = 2'd2
   } biu_size_t;

endpackage

// File: rtl/dmem_arb_pkg.sv
// -----------------------------------------------------------------------------
// dmem_arb_pkg
//  Types and helpers of the dmem round-robin arbiter:
//   arb_state_t  two-state arbiter FSM encoding
//   rr_pick()    round-robin search over a request vector (up to RR_MAX_PORTS)
// -----------------------------------------------------------------------------
package dmem_arb_pkg;

   typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_t;

   localparam int RR_MAX_PORTS = 16;
   localparam int RR_IDX_W     = 4;

   typedef struct packed {
      logic                valid;
      logic [RR_IDX_W-1:0] idx;
   } rr_pick_t;

   // First set bit of req[n-1:0], searching cyclically from last+1.
   // last must be below n, so a single wrap keeps the index in range.
   function automatic rr_pick_t rr_pick(input logic [RR_MAX_PORTS-1:0] req,
                                        input logic [RR_IDX_W-1:0]     last,
                                        input int                      n);
      rr_pick_t res;
      int       j;
      res = '0;
      for (int i = 1; i <= RR_MAX_PORTS; i++) begin
         j = int'(last) + i;
         if (j >= n) j = j - n;
         if ((i <= n) && !res.valid && req[j[RR_IDX_W-1:0]]) begin
            res.valid = 1'b1;
            res.idx   = j[RR_IDX_W-1:0];
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/dmem_rr_pick.sv
// -----------------------------------------------------------------------------
// dmem_rr_pick
//  Combinational round-robin selector.
//  Ports:
//   req    in  PORTS       request vector
//   start  in  clog2(PORTS) pointer of the last winner; search begins at start+1
//   idx    out clog2(PORTS) selected channel
//   valid  out 1           at least one request present
// -----------------------------------------------------------------------------
module dmem_rr_pick
   import dmem_arb_pkg::*;
#(
   parameter int PORTS = 2
) (
   input  logic [PORTS-1:0]         req,
   input  logic [$clog2(PORTS)-1:0] start,
   output logic [$clog2(PORTS)-1:0] idx,
   output logic                     valid
);

   localparam int IW = $clog2(PORTS);

   logic [RR_MAX_PORTS-1:0] req_ext;
   rr_pick_t                res;
   logic                    unused_pick;

   always_comb begin
      req_ext            = '0;
      req_ext[PORTS-1:0] = req;
      res                = rr_pick(req_ext, RR_IDX_W'(start), PORTS);
   end

   assign idx         = res.idx[IW-1:0];
   assign valid       = res.valid;
   assign unused_pick = ^res;

endmodule

// File: rtl/dmem_rr_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_rr_arbiter
//  Merges PORTS core-side dmem request channels onto one dmem bus with
//  round-robin fairness and zero-bubble back-to-back grants. Responses are
//  steered to the granted channel only; read data is broadcast.
//  Optional feature macro: DMEM_ARB_TIMEOUT_EN (forced error after TIMEOUT
//  BUSY cycles without ack/err, sticky tmo_flag).
//  Ports:
//   clk, rstn                        clock, asynchronous active-low reset
//   port_req/adr/d/we/size           per-channel request side (flat vectors)
//   port_q                           mem_q replicated to every channel
//   port_ack/err/misaligned/page_fault  responses, granted channel only
//   mem_req/adr/d/we/size            muxed request to the BIU
//   mem_q/ack/err/misaligned/page_fault responses from the BIU
//   tmo_flag                         sticky timeout indicator
// -----------------------------------------------------------------------------
module dmem_rr_arbiter
   import biu_constants_pkg::*;
   import dmem_arb_pkg::*;
#(
   parameter int XLEN    = 32,
   parameter int PORTS   = 2,
   parameter int TIMEOUT = 255
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic [PORTS-1:0]      port_req,
   input  logic [PORTS*XLEN-1:0] port_adr,
   input  logic [PORTS*XLEN-1:0] port_d,
   input  logic [PORTS-1:0]      port_we,
   input  biu_size_t [PORTS-1:0] port_size,
   output logic [PORTS*XLEN-1:0] port_q,
   output logic [PORTS-1:0]      port_ack,
   output logic [PORTS-1:0]      port_err,
   output logic [PORTS-1:0]      port_misaligned,
   output logic [PORTS-1:0]      port_page_fault,
   output logic                  mem_req,
   output logic [XLEN-1:0]       mem_adr,
   output logic [XLEN-1:0]       mem_d,
   output logic                  mem_we,
   output biu_size_t             mem_size,
   input  logic [XLEN-1:0]       mem_q,
   input  logic                  mem_ack,
   input  logic                  mem_err,
   input  logic                  mem_misaligned,
   input  logic                  mem_page_fault,
   output logic                  tmo_flag
);

   localparam int IW = $clog2(PORTS);

   arb_state_t      state_q, state_d;
   logic [IW-1:0]   grant_q, grant_d;
   logic [IW-1:0]   last_q, last_d;
   logic            tmo_flag_q, tmo_flag_d;

   logic            busy;
   logic            ack_or_err;
   logic            tmo_hit;
   logic [PORTS-1:0] grant_oh;
   logic [PORTS-1:0] pick_req;
   logic [IW-1:0]   pick_start;
   logic [IW-1:0]   pick_idx;
   logic            pick_vld;

   logic [XLEN-1:0] adr_arr [PORTS];
   logic [XLEN-1:0] dat_arr [PORTS];

   assign busy       = (state_q == ARB_BUSY);
   assign ack_or_err = mem_ack | mem_err;

   genvar gi;
   generate
      for (gi = 0; gi < PORTS; gi++) begin : g_chan
         assign grant_oh[gi] = (grant_q == IW'(gi));
         assign adr_arr[gi]  = port_adr[gi*XLEN +: XLEN];
         assign dat_arr[gi]  = port_d[gi*XLEN +: XLEN];
      end
   endgenerate

   // In BUSY the completing channel is excluded, so a lone requester only
   // wins again after passing through IDLE.
   always_comb begin
      pick_req   = busy ? (port_req & ~grant_oh) : port_req;
      pick_start = busy ? grant_q : last_q;
   end

   dmem_rr_pick #(.PORTS(PORTS)) u_pick (
      .req   (pick_req),
      .start (pick_start),
      .idx   (pick_idx),
      .valid (pick_vld)
   );

   // Bus side is driven purely from registered state and grant.
   assign mem_req  = busy;
   assign mem_adr  = adr_arr[grant_q];
   assign mem_d    = dat_arr[grant_q];
   assign mem_we   = port_we[grant_q];
   assign mem_size = port_size[grant_q];
   assign port_q   = {PORTS{mem_q}};
   assign tmo_flag = tmo_flag_q;

`ifdef DMEM_ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT + 1);

   logic [CW-1:0] cnt_q, cnt_d;

   // Fires in the TIMEOUT-th BUSY cycle of a grant; a real ack in that
   // same cycle still wins.
   assign tmo_hit = busy && !ack_or_err && (cnt_q == CW'(TIMEOUT - 1));

   always_comb begin
      cnt_d = cnt_q;
      if (pick_vld && (!busy || ack_or_err)) cnt_d = '0;
      else if (busy && !ack_or_err)          cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end
`else
   logic unused_tmo;
   assign tmo_hit    = 1'b0;
   assign unused_tmo = (TIMEOUT > 0);
`endif

   always_comb begin
      state_d         = state_q;
      grant_d         = grant_q;
      last_d          = last_q;
      tmo_flag_d      = tmo_flag_q;
      port_ack        = '0;
      port_err        = '0;
      port_misaligned = '0;
      port_page_fault = '0;
      case (state_q)
         ARB_IDLE: begin
            // Responses arriving in IDLE belong to nobody and are dropped.
            if (pick_vld) begin
               grant_d = pick_idx;
               last_d  = pick_idx;
               state_d = ARB_BUSY;
            end
         end
         ARB_BUSY: begin
            port_misaligned = grant_oh & {PORTS{mem_misaligned}};
            port_page_fault = grant_oh & {PORTS{mem_page_fault}};
            if (ack_or_err) begin
               port_ack = grant_oh & {PORTS{mem_ack}};
               port_err = grant_oh & {PORTS{mem_err}};
               if (pick_vld) begin
                  grant_d = pick_idx;
                  last_d  = pick_idx;
               end else begin
                  state_d = ARB_IDLE;
               end
            end else if (tmo_hit) begin
               port_err   = grant_oh;
               tmo_flag_d = 1'b1;
               state_d    = ARB_IDLE;
            end
         end
         default: state_d = ARB_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q    <= ARB_IDLE;
         grant_q    <= '0;
         last_q     <= IW'(PORTS - 1);
         tmo_flag_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         last_q     <= last_d;
         tmo_flag_q <= tmo_flag_d;
      end
   end

   // A granted channel must hold its request until the transfer completes.
   a_req_held: assert property (@(posedge clk) disable iff (!rstn)
      (busy && !ack_or_err && !tmo_hit) |-> port_req[grant_q]);

endmodule
